// File: rtl/ahb_matrix_pkg.sv
// Shared AHB-Lite bus-matrix definitions.
// Contents:
//   htrans_e   - transfer type encodings (IDLE/BUSY/NONSEQ/SEQ)
//   hresp_e    - response encodings (OKAY/ERROR)
//   aphase_t   - one captured address phase (addr, trans, write, size, burst, prot)
package ahb_matrix_pkg;

   // Widest address any matrix port uses; narrower ports cast in and out.
   localparam int unsigned AHB_ADDR_W = 32;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic {
      RESP_OKAY  = 1'b0,
      RESP_ERROR = 1'b1
   } hresp_e;

   typedef struct packed {
      logic [AHB_ADDR_W-1:0] addr;
      htrans_e               trans;
      logic                  write;
      logic [2:0]            size;
      logic [2:0]            burst;
      logic [3:0]            prot;
   } aphase_t;

endpackage

// File: rtl/ahblite_busmatrix_inputstage.sv
// Per-manager input stage of the AHB-Lite bus matrix.
// Accepts the manager's address phase; if the output stage cannot take it in
// the same cycle it is held in a single-entry register while wait states are
// inserted. Presents the held or live address phase plus REQ_SUB to the
// arbiters and returns data-phase HREADYOUT/HRESP to the manager.
// Ports:
//   HCLK, HRESETn           - clock, asynchronous active-low reset
//   HSEL..HPROT, HREADY     - manager-side address phase and bus ready
//   HREADYOUT, HRESP        - data-phase ready/response to the manager
//   HADDR_M..HPROT_M        - address phase towards the output stages
//   REQ_SUB                 - transfer pending, to the arbiters
//   ACTIVE_DEC, HREADY_DEC  - grant for this port and output-stage HREADY
//   HREADYOUT_DEC, HRESP_DEC- data-phase ready/response from the subordinate
module ahblite_busmatrix_inputstage
   import ahb_matrix_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [2:0]        HBURST,
   input  logic [3:0]        HPROT,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic              HRESP,
   output logic [ADDR_W-1:0] HADDR_M,
   output logic [1:0]        HTRANS_M,
   output logic              HWRITE_M,
   output logic [2:0]        HSIZE_M,
   output logic [2:0]        HBURST_M,
   output logic [3:0]        HPROT_M,
   output logic              REQ_SUB,
   input  logic              ACTIVE_DEC,
   input  logic              HREADY_DEC,
   input  logic              HREADYOUT_DEC,
   input  logic              HRESP_DEC
);

   logic    new_trans;
   logic    granted;
   logic    pend_valid;
   logic    dphase;
   aphase_t live;
   aphase_t pend;

   // NONSEQ/SEQ only: HTRANS[1] distinguishes them from IDLE/BUSY.
   assign new_trans = HSEL & HTRANS[1] & HREADY;
   assign granted   = ACTIVE_DEC & HREADY_DEC;

   always_comb begin
      live       = '0;
      live.addr  = AHB_ADDR_W'(HADDR);
      live.trans = htrans_e'(HTRANS);
      live.write = HWRITE;
      live.size  = HSIZE;
      live.burst = HBURST;
      live.prot  = HPROT;
   end

   // Loading is gated on an empty register so an unexpected acceptance while
   // waiting can never overwrite a held transfer.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         pend_valid <= 1'b0;
         pend       <= '0;
         dphase     <= 1'b0;
      end else begin
         if (pend_valid && granted) begin
            pend_valid <= 1'b0;
         end else if (!pend_valid && new_trans && !granted) begin
            pend_valid <= 1'b1;
            pend       <= live;
         end

         if (granted && (pend_valid || new_trans)) begin
            dphase <= 1'b1;
         end else if (HREADY_DEC) begin
            dphase <= 1'b0;
         end
      end
   end

   always_comb begin
      if (pend_valid) begin
         HADDR_M  = ADDR_W'(pend.addr);
         HTRANS_M = TRANS_NONSEQ;  // a held SEQ is re-issued as a fresh access
         HWRITE_M = pend.write;
         HSIZE_M  = pend.size;
         HBURST_M = pend.burst;
         HPROT_M  = pend.prot;
      end else begin
         HADDR_M  = HADDR;
         HTRANS_M = (HSEL && HREADY) ? HTRANS : TRANS_IDLE;
         HWRITE_M = HWRITE;
         HSIZE_M  = HSIZE;
         HBURST_M = HBURST;
         HPROT_M  = HPROT;
      end
   end

   assign REQ_SUB   = pend_valid | new_trans;
   assign HREADYOUT = pend_valid ? 1'b0 : (dphase ? HREADYOUT_DEC : 1'b1);
   assign HRESP     = dphase ? HRESP_DEC : RESP_OKAY;

endmodule

// File: tb/tb_ahblite_busmatrix_inputstage.sv
// Bench for ahblite_busmatrix_inputstage: directed manager/output-stage
// sequences, a transaction-level reference checked every cycle, and literal
// expectations at key points of each sequence.
module tb_ahblite_busmatrix_inputstage;
   import ahb_matrix_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HSEL = 1'b0;
   logic [31:0] HADDR = '0;
   logic [1:0]  HTRANS = 2'b00;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = 3'b010;
   logic [2:0]  HBURST = 3'b000;
   logic [3:0]  HPROT = 4'b0011;
   logic        HREADY = 1'b1;
   logic        HREADYOUT, HRESP, HWRITE_M, REQ_SUB;
   logic [31:0] HADDR_M;
   logic [1:0]  HTRANS_M;
   logic [2:0]  HSIZE_M, HBURST_M;
   logic [3:0]  HPROT_M;
   logic        ACTIVE_DEC = 1'b0;
   logic        HREADY_DEC = 1'b1;
   logic        HREADYOUT_DEC = 1'b1;
   logic        HRESP_DEC = 1'b0;

   int unsigned total = 0;
   int unsigned bad = 0;

   ahblite_busmatrix_inputstage #(.ADDR_W(32)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
      .HPROT(HPROT), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
      .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M), .HWRITE_M(HWRITE_M),
      .HSIZE_M(HSIZE_M), .HBURST_M(HBURST_M), .HPROT_M(HPROT_M),
      .REQ_SUB(REQ_SUB), .ACTIVE_DEC(ACTIVE_DEC), .HREADY_DEC(HREADY_DEC),
      .HREADYOUT_DEC(HREADYOUT_DEC), .HRESP_DEC(HRESP_DEC)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%h want=%h", nm, $time, act, exp);
      end
   endtask

   // Reference: a transfer waiting for a grant is a queue entry (at most one);
   // a granted transfer opens a data phase that ends when the output stage
   // reports ready without a further grant.
   aphase_t     wait_q[$];
   aphase_t     nxt_q[$];
   bit          in_dp = 0, nxt_dp = 0;
   bit          wants;
   aphase_t     cur;
   logic [31:0] e_addr;
   logic [1:0]  e_trans;
   logic        e_write;
   logic [2:0]  e_size, e_burst;
   logic [3:0]  e_prot;

   always @(negedge HCLK) begin
      wants = HSEL && HTRANS[1] && HREADY;
      cur = '{addr: HADDR, trans: htrans_e'(HTRANS), write: HWRITE,
              size: HSIZE, burst: HBURST, prot: HPROT};
      if (wait_q.size() != 0) begin
         e_addr = wait_q[0].addr; e_trans = 2'b10; e_write = wait_q[0].write;
         e_size = wait_q[0].size; e_burst = wait_q[0].burst; e_prot = wait_q[0].prot;
      end else begin
         e_addr = HADDR; e_trans = (HSEL && HREADY) ? HTRANS : 2'b00; e_write = HWRITE;
         e_size = HSIZE; e_burst = HBURST; e_prot = HPROT;
      end
      chk("m_haddr",  HADDR_M, e_addr);
      chk("m_htrans", 32'(HTRANS_M), 32'(e_trans));
      chk("m_hwrite", 32'(HWRITE_M), 32'(e_write));
      chk("m_hsize",  32'(HSIZE_M), 32'(e_size));
      chk("m_hburst", 32'(HBURST_M), 32'(e_burst));
      chk("m_hprot",  32'(HPROT_M), 32'(e_prot));
      chk("m_req",    32'(REQ_SUB), 32'(wait_q.size() != 0 || wants));
      chk("m_hreadyout", 32'(HREADYOUT),
          32'(wait_q.size() != 0 ? 1'b0 : (in_dp ? HREADYOUT_DEC : 1'b1)));
      chk("m_hresp", 32'(HRESP), 32'(in_dp ? HRESP_DEC : 1'b0));

      nxt_q = wait_q;
      nxt_dp = in_dp;
      if ((wait_q.size() != 0 || wants) && ACTIVE_DEC && HREADY_DEC) begin
         nxt_q.delete();
         nxt_dp = 1;
      end else begin
         if (wants && wait_q.size() == 0) nxt_q.push_back(cur);
         if (HREADY_DEC) nxt_dp = 0;
      end
   end

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wait_q.delete();
         in_dp = 0;
      end else begin
         wait_q = nxt_q;
         in_dp = nxt_dp;
      end
   end

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic mgr(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic w, input logic [2:0] b, input logic rdy);
      HSEL = sel; HTRANS = tr; HADDR = a; HWRITE = w; HBURST = b; HREADY = rdy;
   endtask

   task automatic dec(input logic act, input logic rdy, input logic rdyout, input logic rsp);
      ACTIVE_DEC = act; HREADY_DEC = rdy; HREADYOUT_DEC = rdyout; HRESP_DEC = rsp;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("rst_hresp",     32'(HRESP), 32'd0);
      chk("rst_req",       32'(REQ_SUB), 32'd0);
      chk("rst_htrans",    32'(HTRANS_M), 32'd0);
      step(); step();
      HRESETn = 1'b1;
      step();

      // Immediate grant
      mgr(1, 2'b10, 32'h4000_0000, 0, 3'b000, 1); dec(1, 1, 1, 0);
      #1;
      chk("imm_haddr", HADDR_M, 32'h4000_0000);
      chk("imm_req",   32'(REQ_SUB), 32'd1);
      chk("imm_htrans", 32'(HTRANS_M), 32'd2);
      step();
      mgr(1, 2'b00, 32'h0, 0, 3'b000, 1); dec(0, 1, 0, 0);
      #1; chk("imm_dp_wait", 32'(HREADYOUT), 32'd0);
      HREADYOUT_DEC = 1'b1;
      #1; chk("imm_dp_ready", 32'(HREADYOUT), 32'd1);
      step();
      HREADYOUT_DEC = 1'b0;
      #1; chk("imm_dp_closed", 32'(HREADYOUT), 32'd1);
      HREADYOUT_DEC = 1'b1;

      // Blocked transfer held for three cycles, then granted
      step();
      mgr(1, 2'b10, 32'h4000_0004, 1, 3'b000, 1); dec(0, 1, 1, 0);
      step();
      mgr(1, 2'b10, 32'h1234_5678, 0, 3'b000, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("blk_hreadyout", 32'(HREADYOUT), 32'd0);
         chk("blk_haddr", HADDR_M, 32'h4000_0004);
         chk("blk_htrans", 32'(HTRANS_M), 32'd2);
         chk("blk_hwrite", 32'(HWRITE_M), 32'd1);
         step();
      end
      dec(1, 1, 1, 0);
      #1; chk("blk_grant_cycle", 32'(HREADYOUT), 32'd0);
      step();
      mgr(1, 2'b00, 32'h0, 0, 3'b000, 1); dec(0, 1, 0, 0);
      #1; chk("blk_dp_follow0", 32'(HREADYOUT), 32'd0);
      chk("blk_req_clear", 32'(REQ_SUB), 32'd0);
      HREADYOUT_DEC = 1'b1;
      #1; chk("blk_dp_follow1", 32'(HREADYOUT), 32'd1);
      step();

      // SEQ captured while blocked keeps its burst and is shown as NONSEQ
      mgr(1, 2'b11, 32'h4000_0008, 0, 3'b011, 1); dec(0, 1, 1, 0);
      step();
      mgr(1, 2'b11, 32'h4000_0008, 0, 3'b011, 0);
      #1;
      chk("seq_htrans", 32'(HTRANS_M), 32'd2);
      chk("seq_hburst", 32'(HBURST_M), 32'd3);
      step();
      dec(1, 1, 1, 0);
      step();
      mgr(1, 2'b00, 32'h0, 0, 3'b000, 1); dec(0, 1, 1, 0);
      step();

      // Two-cycle ERROR response, then the manager cancels with IDLE
      mgr(1, 2'b10, 32'h4000_000C, 1, 3'b000, 1); dec(1, 1, 1, 0);
      step();
      mgr(1, 2'b10, 32'h4000_0010, 1, 3'b000, 0); dec(0, 0, 0, 1);
      #1;
      chk("err1_hresp", 32'(HRESP), 32'd1);
      chk("err1_hreadyout", 32'(HREADYOUT), 32'd0);
      step();
      mgr(1, 2'b00, 32'h4000_0010, 1, 3'b000, 1); dec(0, 1, 1, 1);
      #1;
      chk("err2_hresp", 32'(HRESP), 32'd1);
      chk("err2_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("err2_req", 32'(REQ_SUB), 32'd0);
      step();
      dec(0, 1, 1, 0);
      #1;
      chk("err_after_req", 32'(REQ_SUB), 32'd0);
      chk("err_after_hresp", 32'(HRESP), 32'd0);
      step();

      // IDLE and BUSY with HSEL high
      for (int t = 0; t < 2; t++) begin
         mgr(1, 2'(t), 32'h4000_0020, 0, 3'b001, 1); dec(0, 1, 1, 0);
         #1;
         chk("ib_req", 32'(REQ_SUB), 32'd0);
         chk("ib_hreadyout", 32'(HREADYOUT), 32'd1);
         chk("ib_hresp", 32'(HRESP), 32'd0);
         step();
         #1; chk("ib_not_held", 32'(REQ_SUB), 32'd0);
      end

      // Reset while an entry is pending
      mgr(1, 2'b10, 32'h4000_0030, 1, 3'b000, 1); dec(0, 1, 1, 0);
      step();
      mgr(1, 2'b10, 32'h4000_0030, 1, 3'b000, 0);
      #1;
      chk("rp_req_before", 32'(REQ_SUB), 32'd1);
      HRESETn = 1'b0;
      mgr(0, 2'b00, 32'h0, 0, 3'b000, 1);
      #1;
      chk("rp_req", 32'(REQ_SUB), 32'd0);
      chk("rp_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("rp_htrans", 32'(HTRANS_M), 32'd0);
      step(); step();
      HRESETn = 1'b1;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
